// File: rtl/sram_like_pkg.sv
// sram_like_pkg
// Shared definitions for the SRAM-like memory responder.
//   - transfer size encodings carried on the size port
//   - LFSR tap mask and default seed for the optional random-stall mode
//   - lfsr_next(): one step of the 16-bit Fibonacci LFSR
// The random-stall mode is enabled by defining RANDOM_DELAY_EN.
package sram_like_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr_next(input logic [15:0] state);
      return {state[14:0], ^(state & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// sram_like_resp_fifo
// In-order outstanding-response queue for sram_like_slave.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (control only)
//   push, push_data   enqueue one entry (caller guarantees not full)
//   pop               dequeue the head entry (ignored when empty)
//   count             number of valid entries, 0..DEPTH
//   head              head entry contents, meaningful only when count != 0
module sram_like_resp_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 33
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [WIDTH-1:0]             head
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count != CNT_W'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = store[rd_ptr];

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage carries data only; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/sram_like_slave.sv
// sram_like_slave
// Memory-side responder for the SRAM-like request/response interface.
// Backs a 2^ADDR_W x 32-bit word array and answers accepted requests
// strictly in order through a DEPTH-entry response FIFO.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (array not reset)
//   req, wr, size     request valid, write flag, transfer size (not used)
//   wstrb, addr       byte-lane enables, byte address (word = addr[ADDR_W+1:2])
//   wdata             lane-aligned write data
//   addr_ok           request accepted this cycle
//   data_ok, rdata    one response this cycle, read data (0 for writes)
// Optional: define RANDOM_DELAY_EN to add LFSR-driven accept/response stalls.
module sram_like_slave
   import sram_like_pkg::*;
#(
   parameter int          ADDR_W = 12,
   parameter int          DEPTH  = 2,
   parameter logic [15:0] SEED   = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int CNT_W = $clog2(DEPTH+1);

   logic [31:0]       mem [2**ADDR_W];
   logic [ADDR_W-1:0] idx;
   logic [CNT_W-1:0]  count;
   logic [32:0]       head;
   logic [32:0]       push_data;
   logic              stall_accept;
   logic              stall_resp;
   logic              unused_bits;

   assign idx = addr[ADDR_W+1:2];

   // Size is informational and the remaining address bits are ignored.
   assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

`ifdef RANDOM_DELAY_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr <= SEED;
      else       lfsr <= lfsr_next(lfsr);
   end

   assign stall_accept = lfsr[0];
   assign stall_resp   = lfsr[1];
`else
   assign stall_accept = 1'b0;
   assign stall_resp   = 1'b0;
`endif

   // Full blocks acceptance even when a pop happens this same cycle.
   assign addr_ok = req & (count < CNT_W'(DEPTH)) & ~reset & ~stall_accept;
   assign data_ok = (count != '0) & ~stall_resp;

   // Write responses carry zero data; an empty FIFO also drives zero.
   assign rdata = ((count != '0) && !head[32]) ? head[31:0] : 32'h0;

   // Read data is sampled before this edge's write, but a read and a write
   // are never accepted in the same cycle, so earlier writes are visible.
   assign push_data = wr ? {1'b1, 32'h0} : {1'b0, mem[idx]};

   always_ff @(posedge clk) begin
      if (addr_ok && wr) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   sram_like_resp_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (33)
   ) u_resp_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (addr_ok),
      .push_data (push_data),
      .pop       (data_ok),
      .count     (count),
      .head      (head)
   );

endmodule
